// File: rtl/alu_share_arbiter.sv
// Two requesters share one AND/OR/XOR/ADD unit through round-robin arbitration.
// One operation is in flight at a time, and its result is registered.
module alu_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic             rsp_carry,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rid_q, rid_d, carry_q, carry_d, zero_q, zero_d;

  logic             grant_any, grant_id;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  // When both requesters are valid, the one not served last time wins.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_q : req1_valid;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    alu_res   = a_q & b_q;
    alu_carry = 1'b0;
    case (op_q)
      2'b01:   alu_res = a_q | b_q;
      2'b10:   alu_res = a_q ^ b_q;
      2'b11: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      default: alu_res = a_q & b_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    valid_d    = valid_q;
    result_d   = result_q;
    rid_d      = rid_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a  : req0_a;
          b_d        = grant_id ? req1_b  : req0_b;
          op_d       = grant_id ? req1_op : req0_op;
          id_d       = grant_id;
          last_d     = grant_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_res;
        carry_d  = alu_carry;
        zero_d   = (alu_res == '0);
        rid_d    = id_q;
        valid_d  = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        // Result fields stay put after the drain until the next EXEC.
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      id_q     <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rid_q    <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rid_q    <= rid_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign rsp_valid  = valid_q;
  assign rsp_result = result_q;
  assign rsp_id     = rid_q;
  assign rsp_carry  = carry_q;
  assign rsp_zero   = zero_q;

endmodule
